// File: rtl/main_udiv_18ns_9ns_seq.sv
// Sequential unsigned divider: radix-2 restoring division, one quotient bit per
// enabled cycle, start/done handshake toward the kernel FSM.
module main_udiv_18ns_9ns_seq #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 19,
   parameter int din0_WIDTH = 18,
   parameter int din1_WIDTH = 9
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [din0_WIDTH-1:0] quot,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  div_by_zero,
   output logic [1:0]            o_dbg_state
);

   localparam int CW = $clog2(din0_WIDTH + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // ID and NUM_STAGE are informational tags only.
   if (ID < 0 || NUM_STAGE < 0) begin : g_info_params
   end

   logic [1:0]            r_state;
   logic [CW-1:0]         r_cnt;
   logic [din0_WIDTH-1:0] r_dvd;
   logic [din1_WIDTH-1:0] r_dvsr;
   logic [din1_WIDTH-1:0] r_prem;
   logic                  r_done;
   logic [din0_WIDTH-1:0] r_quot;
   logic [din1_WIDTH-1:0] r_rem;
   logic                  r_dz;

   logic [din1_WIDTH:0]   w_shift;
   logic [din1_WIDTH-1:0] w_diff;
   logic                  w_qbit;

   // Shifted partial remainder is one bit wider than the divisor; the kept value
   // is always below the divisor, so only din1_WIDTH bits need to be stored.
   // With a zero divisor every subtract succeeds and the top bit truncates away.
   assign w_shift = {r_prem, r_dvd[din0_WIDTH-1]};
   assign w_qbit  = (w_shift >= {1'b0, r_dvsr});
   assign w_diff  = w_shift[din1_WIDTH-1:0] - r_dvsr;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_dvd   <= '0;
         r_dvsr  <= '0;
         r_prem  <= '0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dz    <= 1'b0;
      end else if (ce) begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_dvd   <= din0;
                  r_dvsr  <= din1;
                  r_prem  <= '0;
                  r_cnt   <= CW'(din0_WIDTH - 1);
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Quotient bits shift in behind the dividend bits being consumed.
               r_prem <= w_qbit ? w_diff : w_shift[din1_WIDTH-1:0];
               r_dvd  <= {r_dvd[din0_WIDTH-2:0], w_qbit};
               if (r_cnt == '0) begin
                  r_state <= ST_FIN;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_FIN: begin
               r_quot  <= r_dvd;
               r_rem   <= r_prem;
               r_dz    <= (r_dvsr == '0);
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready       = (r_state == ST_IDLE);
   assign done        = r_done;
   assign quot        = r_quot;
   assign rem         = r_rem;
   assign div_by_zero = r_dz;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_main_udiv_18ns_9ns_seq.sv
// Directed bench for the sequential divider: vector table plus hand-written
// sequences for clock-enable stalls, streaming starts and mid-run reset.
module tb_main_udiv_18ns_9ns_seq;

   logic        ap_clk;
   logic        ap_rst;
   logic        ce;
   logic        start;
   logic [17:0] din0;
   logic [8:0]  din1;
   logic        ready;
   logic        done;
   logic [17:0] quot;
   logic [8:0]  rem;
   logic        div_by_zero;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [17:0] a;
      logic [8:0]  b;
      logic [17:0] q;
      logic [8:0]  r;
      logic        dz;
   } vec_t;

   vec_t vecs[12];
   logic [27:0] exp_q[$];

   main_udiv_18ns_9ns_seq dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .ce          (ce),
      .start       (start),
      .din0        (din0),
      .din1        (din1),
      .ready       (ready),
      .done        (done),
      .quot        (quot),
      .rem         (rem),
      .div_by_zero (div_by_zero),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   function automatic logic [27:0] model(input logic [17:0] a, input logic [8:0] b);
      if (b == 9'd0) return {1'b1, 18'h3FFFF, a[8:0]};
      return {1'b0, 18'(a / b), 9'(a % b)};
   endfunction

   // driver: one complete division with latency and hold checks
   task automatic run_div(input vec_t v, input string tag);
      int n;
      n = 0;
      while (!ready && n < 100) begin
         step();
         n++;
      end
      check({tag, "_ready_in"}, 32'(ready), 32'd1);
      din0  = v.a;
      din1  = v.b;
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_ready_drop"}, 32'(ready), 32'd0);
      din0 = 18'($urandom_range(0, 262143));
      din1 = 9'($urandom_range(0, 511));
      n = 0;
      while (!done && n < 100) begin
         step();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd19);
      check({tag, "_quot"}, 32'(quot), 32'(v.q));
      check({tag, "_rem"}, 32'(rem), 32'(v.r));
      check({tag, "_dz"}, 32'(div_by_zero), 32'(v.dz));
      check({tag, "_ready_at_done"}, 32'(ready), 32'd1);
      step();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold_quot"}, 32'(quot), 32'(v.q));
      check({tag, "_hold_rem"}, 32'(rem), 32'(v.r));
   endtask

   initial begin
      int lat;
      int ndone;
      int last;
      logic got;
      logic [27:0] e;
      vec_t v;

      vecs[0]  = '{18'd1000,   9'd7,   18'd142,    9'd6,   1'b0};
      vecs[1]  = '{18'd262143, 9'd1,   18'd262143, 9'd0,   1'b0};
      vecs[2]  = '{18'd300,    9'd300, 18'd1,      9'd0,   1'b0};
      vecs[3]  = '{18'd255,    9'd511, 18'd0,      9'd255, 1'b0};
      vecs[4]  = '{18'd100,    9'd0,   18'd262143, 9'd100, 1'b1};
      vecs[5]  = '{18'd50,     9'd5,   18'd10,     9'd0,   1'b0};
      vecs[6]  = '{18'd131071, 9'd3,   18'd43690,  9'd1,   1'b0};
      vecs[7]  = '{18'd0,      9'd9,   18'd0,      9'd0,   1'b0};
      vecs[8]  = '{18'd262143, 9'd511, 18'd513,    9'd0,   1'b0};
      vecs[9]  = '{18'd262143, 9'd0,   18'd262143, 9'd511, 1'b1};
      vecs[10] = '{18'd12345,  9'd100, 18'd123,    9'd45,  1'b0};
      vecs[11] = '{18'd1,      9'd511, 18'd0,      9'd1,   1'b0};

      ap_rst = 1'b1;
      ce     = 1'b1;
      start  = 1'b0;
      din0   = '0;
      din1   = '0;
      repeat (3) step();
      ap_rst = 1'b0;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quot", 32'(quot), 32'd0);
      check("rst_rem", 32'(rem), 32'd0);
      check("rst_dz", 32'(div_by_zero), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);

      // start with ce low in IDLE must not be sampled
      ce    = 1'b0;
      start = 1'b1;
      din0  = 18'd5;
      din1  = 9'd1;
      repeat (3) step();
      start = 1'b0;
      ce    = 1'b1;
      check("ce_idle_ready", 32'(ready), 32'd1);
      step();
      check("ce_idle_no_done", 32'(done), 32'd0);

      for (int i = 0; i < 12; i++) begin
         run_div(vecs[i], $sformatf("vec%0d", i));
      end

      // ce low 5 cycles mid-run and 1 cycle in FIN
      din0  = 18'd65535;
      din1  = 9'd255;
      start = 1'b1;
      step();
      start = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         ce = !((k >= 5 && k <= 9) || k == 24);
         step();
         if (done) begin
            got = 1'b1;
            lat = k;
         end
      end
      ce = 1'b1;
      check("stall_latency", 32'(lat), 32'd25);
      check("stall_quot", 32'(quot), 32'd257);
      check("stall_rem", 32'(rem), 32'd0);
      check("stall_dz", 32'(div_by_zero), 32'd0);
      ndone = 0;
      repeat (5) begin
         step();
         if (done) ndone++;
      end
      check("stall_no_dup_done", 32'(ndone), 32'd0);

      // continuous start with changing operands, scoreboard against model
      last = -1;
      for (int cyc = 0; cyc < 140; cyc++) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("sb_spurious_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_result", 32'({div_by_zero, quot, rem}), 32'(e));
            end
            if (last >= 0) check("sb_gap", 32'(cyc - last), 32'd20);
            last = cyc;
         end
         start = (cyc < 100);
         din0  = 18'($urandom_range(0, 262143));
         din1  = 9'($urandom_range(0, 511));
         if (start && ready) exp_q.push_back(model(din0, din1));
         step();
      end
      start = 1'b0;
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      // reset at RUN step 9 aborts without done
      din0  = 18'd1000;
      din1  = 9'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_quot", 32'(quot), 32'd0);
      check("abort_rem", 32'(rem), 32'd0);
      check("abort_dz", 32'(div_by_zero), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      ndone = 0;
      repeat (25) begin
         step();
         if (done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      v = '{18'd77, 9'd10, 18'd7, 9'd7, 1'b0};
      run_div(v, "post_abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
